// File: rtl/scope_cmd_pkg.sv
// Shared types and constants for the oscilloscope command engine:
// opcodes, FSM states, response codes, slave selects and the AFE gain table.
package scope_cmd_pkg;

    typedef enum logic [7:0] {
        OP_DUMP     = 8'h01,
        OP_GAIN     = 8'h02,
        OP_TRIG     = 8'h03,
        OP_TPOS     = 8'h04,
        OP_DEC      = 8'h05,
        OP_TCFG_WR  = 8'h06,
        OP_TCFG_RD  = 8'h07,
        OP_EEP_WR   = 8'h08,
        OP_EEP_RD   = 8'h09,
        OP_EEP_PAIR = 8'h0A
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_SPI_ISSUE,
        ST_SPI_WAIT,
        ST_GAP,
        ST_RESP,
        ST_WAIT_SENT
    } state_t;

    localparam logic [7:0] ACK        = 8'hA5;
    localparam logic [7:0] NAK        = 8'hEE;
    localparam logic [2:0] SS_TRIG    = 3'd0;
    localparam logic [2:0] SS_EEP     = 3'd4;
    localparam logic [7:0] SPI_WR_CMD = 8'h13;

    // AFE gain code -> DAC setting written over SPI.
    function automatic logic [7:0] gain_lut(input logic [2:0] g);
        logic [7:0] v;
        case (g)
            3'd0:    v = 8'h02;
            3'd1:    v = 8'h05;
            3'd2:    v = 8'h09;
            3'd3:    v = 8'h14;
            3'd4:    v = 8'h28;
            3'd5:    v = 8'h46;
            3'd6:    v = 8'h6B;
            default: v = 8'hDD;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/scope_cmd_engine_if.sv
// Host-link bundle: UART command/response path and SPI master path.
interface scope_cmd_engine_if;
    // Handshakes: cmd is valid while cmd_rdy is high and stays until the engine
    // pulses clr_cmd_rdy; send_resp pulses once with resp_data valid and the
    // engine waits for resp_sent; wrt_SPI pulses once and ss/SPI_data hold until
    // SPI_done, which also qualifies EEP_data.
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp_data;
    logic        send_resp;
    logic        resp_sent;
    logic [15:0] SPI_data;
    logic        wrt_SPI;
    logic [2:0]  ss;
    logic        SPI_done;
    logic [7:0]  EEP_data;

    modport master (
        input  cmd, cmd_rdy, resp_sent, SPI_done, EEP_data,
        output clr_cmd_rdy, resp_data, send_resp, SPI_data, wrt_SPI, ss
    );

    modport slave (
        output cmd, cmd_rdy, resp_sent, SPI_done, EEP_data,
        input  clr_cmd_rdy, resp_data, send_resp, SPI_data, wrt_SPI, ss
    );
endinterface

// File: rtl/scope_cmd_engine_spi_txn_ctrl.sv
// SPI transaction timing: registered start pulse, inter-word gap counter and
// SPI_done watchdog. SPI_GAP must be at least 2.
module spi_txn_ctrl #(
    parameter int SPI_GAP = 4,
    parameter int TO_CYC  = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic issue,
    input  logic waiting,
    input  logic in_gap,
    input  logic spi_done,
    output logic wrt_spi,
    output logic done,
    output logic timeout,
    output logic gap_done
);
    localparam int WD_W  = $clog2(TO_CYC);
    localparam int GAP_W = $clog2(SPI_GAP) + 1;

    logic [WD_W-1:0]  wd_cnt;
    logic [GAP_W-1:0] gap_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrt_spi <= 1'b0;
            wd_cnt  <= '0;
            gap_cnt <= '0;
        end else begin
            wrt_spi <= issue;
            wd_cnt  <= waiting ? wd_cnt + 1'b1 : '0;
            gap_cnt <= in_gap ? gap_cnt + 1'b1 : '0;
        end
    end

    // The issue state adds one more quiet cycle, so the gap state lasts SPI_GAP-1.
    assign done     = waiting & spi_done;
    assign timeout  = waiting & ~spi_done & (wd_cnt == WD_W'(TO_CYC - 1));
    assign gap_done = in_gap & (gap_cnt == GAP_W'(SPI_GAP - 2));
endmodule

// File: rtl/scope_cmd_engine.sv
// Command engine: decodes host commands, updates capture configuration, runs
// SPI writes/reads to AFE gain, trigger DAC and EEPROM, and returns a response.
module scope_cmd_engine
    import scope_cmd_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int DEC_W    = 4,
    parameter int TPOS_W   = 9,
    parameter int TRIG_MIN = 46,
    parameter int TRIG_MAX = 201,
    parameter int SPI_GAP  = 4,
    parameter int TO_CYC   = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    scope_cmd_engine_if.master  bus,
    input  logic                set_cap_done,
    output logic [1:0]          dump_chan,
    output logic                dump_en,
    output logic [DEC_W-1:0]    decimator,
    output logic [TPOS_W-1:0]   trig_pos,
    output logic [7:0]          trig_cfg,
    output logic [3*NUM_CH-1:0] gain,
    output logic [15:0]         EEP_cfg_data,
    output logic                eep_done,
    output state_t              dbg_state
);
    localparam logic [7:0] TMIN = 8'(TRIG_MIN);
    localparam logic [7:0] TMAX = 8'(TRIG_MAX);

    state_t      state;
    logic [7:0]  op_q;
    logic [13:0] arg_q;
    logic [15:0] word_a, word_b;
    logic [2:0]  ss_t;
    logic [1:0]  txn_idx, txn_last;
    logic [7:0]  byte_a, resp_val;

    logic [1:0] cc;
    logic [2:0] g;
    logic [5:0] ea, ea_nxt;
    logic [7:0] b3, trig_lvl;
    logic       cc_bad;
    logic       wrt_spi, txn_done, txn_timeout, gap_done;

    assign cc       = arg_q[9:8];
    assign g        = arg_q[12:10];
    assign ea       = arg_q[13:8];
    assign ea_nxt   = ea + 6'd1;
    assign b3       = arg_q[7:0];
    assign trig_lvl = (b3 < TMIN) ? TMIN : (b3 > TMAX) ? TMAX : b3;
    assign cc_bad   = ({30'd0, cc} >= 32'(NUM_CH));

    spi_txn_ctrl #(.SPI_GAP(SPI_GAP), .TO_CYC(TO_CYC)) u_spi_txn (
        .clk      (clk),
        .rst_n    (rst_n),
        .issue    (state == ST_SPI_ISSUE),
        .waiting  (state == ST_SPI_WAIT),
        .in_gap   (state == ST_GAP),
        .spi_done (bus.SPI_done),
        .wrt_spi  (wrt_spi),
        .done     (txn_done),
        .timeout  (txn_timeout),
        .gap_done (gap_done)
    );

    assign bus.wrt_SPI = wrt_spi;
    assign dbg_state   = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            op_q             <= '0;
            arg_q            <= '0;
            word_a           <= '0;
            word_b           <= '0;
            ss_t             <= '0;
            txn_idx          <= '0;
            txn_last         <= '0;
            byte_a           <= '0;
            resp_val         <= '0;
            bus.clr_cmd_rdy  <= 1'b0;
            bus.resp_data    <= '0;
            bus.send_resp    <= 1'b0;
            bus.SPI_data     <= '0;
            bus.ss           <= '0;
            dump_chan        <= '0;
            dump_en          <= 1'b0;
            decimator        <= '0;
            trig_pos         <= '0;
            trig_cfg         <= '0;
            gain             <= '0;
            EEP_cfg_data     <= '0;
            eep_done         <= 1'b0;
        end else begin
            bus.clr_cmd_rdy <= 1'b0;
            bus.send_resp   <= 1'b0;
            dump_en         <= 1'b0;
            eep_done        <= 1'b0;
            // Capture-done flag; an 0x06 write in the same cycle overrides it below.
            if (set_cap_done) trig_cfg[5] <= 1'b1;

            case (state)
                ST_IDLE: begin
                    // clr_cmd_rdy high means cmd_rdy is the retired command still falling.
                    if (bus.cmd_rdy && !bus.clr_cmd_rdy) begin
                        op_q  <= bus.cmd[23:16];
                        arg_q <= bus.cmd[13:0];
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    resp_val <= ACK;
                    state    <= ST_RESP;
                    txn_idx  <= '0;
                    txn_last <= '0;
                    ss_t     <= SS_EEP;
                    word_a   <= {2'b00, ea, 8'h00};
                    word_b   <= {2'b00, ea_nxt, 8'h00};
                    case (op_q)
                        OP_DUMP: begin
                            if (cc_bad) resp_val <= NAK;
                            else begin
                                dump_chan <= cc;
                                dump_en   <= 1'b1;
                            end
                        end
                        OP_GAIN: begin
                            if (cc_bad) resp_val <= NAK;
                            else begin
                                for (int c = 0; c < NUM_CH; c++)
                                    if (cc == 2'(c)) gain[3*c +: 3] <= g;
                                ss_t   <= {1'b0, cc} + 3'd1;
                                word_a <= {SPI_WR_CMD, gain_lut(g)};
                                state  <= ST_SPI_ISSUE;
                            end
                        end
                        OP_TRIG: begin
                            ss_t   <= SS_TRIG;
                            word_a <= {SPI_WR_CMD, trig_lvl};
                            state  <= ST_SPI_ISSUE;
                        end
                        OP_TPOS:    trig_pos  <= arg_q[TPOS_W-1:0];
                        OP_DEC:     decimator <= arg_q[DEC_W-1:0];
                        OP_TCFG_WR: trig_cfg  <= {2'b00, arg_q[13:8]};
                        OP_TCFG_RD: resp_val  <= {2'b00, trig_cfg[5:0]};
                        OP_EEP_WR: begin
                            word_a <= {2'b01, arg_q};
                            state  <= ST_SPI_ISSUE;
                        end
                        OP_EEP_RD: begin
                            txn_last <= 2'd1;
                            state    <= ST_SPI_ISSUE;
                        end
                        OP_EEP_PAIR: begin
                            txn_last <= 2'd3;
                            state    <= ST_SPI_ISSUE;
                        end
                        default: resp_val <= NAK;
                    endcase
                end
                ST_SPI_ISSUE: begin
                    bus.ss       <= ss_t;
                    bus.SPI_data <= txn_idx[1] ? word_b : word_a;
                    state        <= ST_SPI_WAIT;
                end
                ST_SPI_WAIT: begin
                    if (txn_done) begin
                        if (txn_idx == 2'd1) byte_a <= bus.EEP_data;
                        if (txn_idx == txn_last) begin
                            state <= ST_RESP;
                            if (op_q == OP_EEP_RD) resp_val <= bus.EEP_data;
                            else if (op_q == OP_EEP_PAIR) begin
                                resp_val     <= byte_a;
                                EEP_cfg_data <= {byte_a, bus.EEP_data};
                                eep_done     <= 1'b1;
                            end
                        end else begin
                            txn_idx <= txn_idx + 2'd1;
                            state   <= ST_GAP;
                        end
                    end else if (txn_timeout) begin
                        resp_val <= NAK;
                        state    <= ST_RESP;
                    end
                end
                ST_GAP: begin
                    if (gap_done) state <= ST_SPI_ISSUE;
                end
                ST_RESP: begin
                    bus.resp_data <= resp_val;
                    bus.send_resp <= 1'b1;
                    state         <= ST_WAIT_SENT;
                end
                ST_WAIT_SENT: begin
                    if (bus.resp_sent) begin
                        bus.clr_cmd_rdy <= 1'b1;
                        state           <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/scope_cmd_engine.md
# scope_cmd_engine

Parametrised command engine for the oscilloscope host link: takes 24-bit commands from the UART command receiver, updates the capture configuration registers, runs SPI transactions to the per-channel AFE gain, the trigger DAC and the calibration EEPROM, and returns a one-byte response. It sits between the UART command/response path and the SPI master, trigger and capture blocks. It is the successor to the fixed 3-channel command configuration block. It adds per-channel gain registers, a 16-bit EEPROM pair read, an SPI watchdog, and fully registered outputs.

## Interface
- NUM_CH, 3, analog channels (1..3)
- DEC_W, 4, decimator width
- TPOS_W, 9, trigger-position width (≤14)
- TRIG_MIN, 46, lowest legal trigger level
- TRIG_MAX, 201, highest legal trigger level
- SPI_GAP, 4, idle cycles between back-to-back SPI transactions
- TO_CYC, 4096, SPI_done watchdog limit in cycles
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- cmd  in  24  {opcode[23:16], b2[15:8], b3[7:0]}
- cmd_rdy  in  1  cmd valid, held until clr_cmd_rdy
- clr_cmd_rdy  out  1  one-cycle pulse, command retired
- resp_data  out  8  response byte
- send_resp  out  1  one-cycle pulse to UART transmitter
- resp_sent  in  1  UART transmit complete
- SPI_data  out  16  SPI word
- wrt_SPI  out  1  one-cycle SPI start pulse
- ss  out  3  slave select: 0 trigger DAC, 1..NUM_CH channel gain, 4 EEPROM
- SPI_done  in  1  SPI transaction complete pulse
- EEP_data  in  8  EEPROM read byte, valid with SPI_done
- set_cap_done  in  1  capture finished
- dump_chan  out  2; dump_en  out  1 (one-cycle pulse)
- decimator  out  DEC_W; trig_pos  out  TPOS_W; trig_cfg  out  8
- gain  out  3*NUM_CH  gain of channel c at [3c+2:3c]
- EEP_cfg_data  out  16; eep_done  out  1 (one-cycle pulse)

## Operation
- Opcode decoded exactly on cmd[23:16]. cc = cmd[9:8]. Undefined opcodes, and cc ≥ NUM_CH where a channel is used, respond 8'hEE with no register or SPI side effect.
- ACK = 8'hA5.
- 0x01: dump_chan<=cc, dump_en pulse, ACK.
- 0x02: gain[cc]<=cmd[12:10]; SPI {8'h13, LUT[g]} to ss=cc+1, ACK after SPI_done. LUT: 02,05,09,14,28,46,6B,DD.
- 0x03: SPI {8'h13, clamp(b3,TRIG_MIN,TRIG_MAX)} to ss=0, ACK after SPI_done.
- 0x04: trig_pos<=cmd[TPOS_W-1:0], ACK.
- 0x05: decimator<=cmd[DEC_W-1:0], ACK.
- 0x06: trig_cfg[5:0]<=cmd[13:8], ACK.
- 0x07: resp {2'b00, trig_cfg[5:0]}.
- 0x08: SPI {2'b01, cmd[13:0]} to ss=4, ACK after SPI_done.
- 0x09: two SPI words {2'b00, a, 8'h00}. Response = EEP_data captured at the second SPI_done.
- 0x0A: pair read. Address a, then a+1 (6-bit wrap, 63→0), two words each. EEP_cfg_data <= {byte(a), byte(a+1)}, eep_done pulse, response = byte(a).
- set_cap_done sets trig_cfg[5]. If it coincides with an 0x06 write, the write wins. trig_cfg[7:6] are always 0.
- Watchdog: if no SPI_done within TO_CYC cycles of wrt_SPI, abort, respond 8'hEE, keep already-updated registers.
- FSM: IDLE → DECODE (cmd_rdy) → SPI_ISSUE → SPI_WAIT → [GAP → SPI_ISSUE]* → RESP → WAIT_SENT → IDLE (resp_sent, pulse clr_cmd_rdy). Non-SPI opcodes go DECODE → RESP.

## Timing
- Reset: every output and register is 0, FSM in IDLE.
- cmd_rdy sampled in IDLE; DECODE the next cycle; register updates visible the cycle after DECODE.
- wrt_SPI is registered and asserted in the cycle after SPI_ISSUE. ss/SPI_data are stable from that cycle until SPI_done.
- Between transactions, SPI_GAP idle cycles separate SPI_done from the next wrt_SPI.
- resp_data is valid in the same cycle as send_resp and is held until the next response.
- clr_cmd_rdy is asserted the cycle after resp_sent.
- SPI_done or resp_sent outside the wait states is ignored.
- rst_n mid-command aborts immediately, with no response.

## Structure
- Package scope_cmd_pkg: opcode enum, state_t enum, ACK/NAK constants, SS_TRIG/SS_EEP constants, gain LUT function.
- One sub-module, spi_txn_ctrl: issue pulse, gap counter and watchdog counter; reports done/timeout to the FSM.

## Test plan
- 0x020600 (g=1, cc=2), NUM_CH=3 → SPI 16'h1305 on ss=3; gain[8:6]=1; resp A5; clr_cmd_rdy after resp_sent.
- 0x0300FF, then 0x030010 → SPI 16'h13C9, then 16'h132E, both on ss=0.
- 0x0A3F00 with EEPROM[63]=8'h12, [0]=8'h34 → four SPI words, EEP_cfg_data=16'h1234, eep_done pulse, resp 12.
- 0x082A55 with SPI_done withheld TO_CYC cycles → resp EE, FSM back to IDLE, no further wrt_SPI.
- 0x061500 coinciding with set_cap_done → trig_cfg=8'h15; then set_cap_done alone → 8'h35; 0x070000 → resp 35.
- 0x7F0000 → resp EE, no register change. rst_n pulsed during SPI_WAIT → all outputs 0, no send_resp.
